// File: rtl/calc_key_entry.sv
// calc_key_entry: debounces 12 push keys and assembles operand A, operator and operand B for the calculator
// Ports:
//   clk, rst        system clock; asynchronous active-low reset
//   i_tick          one-clk sample strobe for the debouncers
//   i_sw_push[11:0] raw keys: [9:0] digits 0-9, [10] OP, [11] EQ
//   i_op_sel[2:0]   operator DIP switches, latched when OP is accepted
//   i_ready         downstream accepts the completed expression
//   o_opa, o_opb    live operand accumulators
//   o_op            latched operator code
//   o_valid         expression complete, held until accepted
//   o_char          ASCII of the last accepted key, o_char_stb pulses on update
//   o_err           one-clk pulse on a rejected key
//   o_state         FSM state for debug LEDs
module calc_key_entry #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int MAX_DIGITS     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic [11:0] i_sw_push,
    input  logic [2:0]  i_op_sel,
    input  logic        i_ready,
    output logic [7:0]  o_opa,
    output logic [7:0]  o_opb,
    output logic [2:0]  o_op,
    output logic        o_valid,
    output logic [7:0]  o_char,
    output logic        o_char_stb,
    output logic        o_err,
    output logic [1:0]  o_state
);
    localparam logic [3:0] DB_N  = 4'(DEBOUNCE_TICKS);
    localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);
    localparam logic [3:0] K_OP  = 4'd10;

    typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OUT = 2'd2} state_t;
    state_t state, state_nx;

    logic [11:0] lvl, lvl_nx, rise;
    logic [3:0]  db_cnt    [12];
    logic [3:0]  db_cnt_nx [12];
    logic        ev_vld, ev_hit;
    logic [3:0]  ev_key, ev_idx;

    always_comb begin
        lvl_nx = lvl;
        for (int i = 0; i < 12; i++) begin
            db_cnt_nx[i] = db_cnt[i];
            if (i_tick) begin
                if (i_sw_push[i] == lvl[i]) db_cnt_nx[i] = '0;
                else if (db_cnt[i] + 4'd1 == DB_N) begin
                    lvl_nx[i]    = ~lvl[i];
                    db_cnt_nx[i] = '0;
                end
                else db_cnt_nx[i] = db_cnt[i] + 4'd1;
            end
        end
    end

    // Only keys whose level rises on this tick are events; the lowest index wins
    // and the rest are lost because their level is already high afterwards.
    assign rise = lvl_nx & ~lvl;

    always_comb begin
        ev_hit = |rise;
        ev_idx = '0;
        for (int i = 11; i >= 0; i--)
            if (rise[i]) ev_idx = 4'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl    <= '0;
            ev_vld <= 1'b0;
            ev_key <= '0;
            for (int i = 0; i < 12; i++) db_cnt[i] <= '0;
        end else begin
            lvl    <= lvl_nx;
            ev_vld <= ev_hit;
            ev_key <= ev_idx;
            for (int i = 0; i < 12; i++) db_cnt[i] <= db_cnt_nx[i];
        end
    end

    logic [7:0]  acc_a, acc_b, acc_a_nx, acc_b_nx, char_nx;
    logic [3:0]  cnt_a, cnt_b, cnt_a_nx, cnt_b_nx, cnt_cur;
    logic [11:0] prod;
    logic [2:0]  op_nx;
    logic        stb_nx, err_nx, in_b, dig_ok, op_ok;

    function automatic logic [7:0] op_char(input logic [2:0] op);
        case (op)
            3'd0:    return 8'h2B;
            3'd1:    return 8'h2D;
            3'd2:    return 8'hD7;
            3'd3:    return 8'h2F;
            3'd4:    return 8'hF7;
            3'd5:    return 8'h5E;
            3'd6:    return 8'h21;
            default: return 8'h00;
        endcase
    endfunction

    // Digit append is evaluated at 12 bits so an overflowing result is caught before truncation.
    assign in_b    = state == S_B;
    assign cnt_cur = in_b ? cnt_b : cnt_a;
    assign prod    = {4'd0, in_b ? acc_b : acc_a} * 12'd10 + {8'd0, ev_key};
    assign dig_ok  = cnt_cur < MAX_D && prod <= 12'd255;
    assign op_ok   = state == S_A && cnt_a != 4'd0 && i_op_sel != 3'd7;

    always_comb begin
        state_nx = state;
        acc_a_nx = acc_a;
        acc_b_nx = acc_b;
        cnt_a_nx = cnt_a;
        cnt_b_nx = cnt_b;
        op_nx    = o_op;
        char_nx  = o_char;
        stb_nx   = 1'b0;
        err_nx   = 1'b0;
        if (state == S_OUT) begin
            if (i_ready) begin
                state_nx = S_A;
                acc_a_nx = '0;
                acc_b_nx = '0;
                cnt_a_nx = '0;
                cnt_b_nx = '0;
            end
        end else if (ev_vld) begin
            if (ev_key < K_OP) begin
                if (!dig_ok) err_nx = 1'b1;
                else begin
                    if (in_b) begin
                        acc_b_nx = prod[7:0];
                        cnt_b_nx = cnt_b + 4'd1;
                    end else begin
                        acc_a_nx = prod[7:0];
                        cnt_a_nx = cnt_a + 4'd1;
                    end
                    char_nx = 8'h30 + {4'd0, ev_key};
                    stb_nx  = 1'b1;
                end
            end else if (ev_key == K_OP) begin
                if (!op_ok) err_nx = 1'b1;
                else begin
                    op_nx    = i_op_sel;
                    char_nx  = op_char(i_op_sel);
                    stb_nx   = 1'b1;
                    acc_b_nx = '0;
                    state_nx = i_op_sel == 3'd6 ? S_OUT : S_B;
                end
            end else if (state == S_B && cnt_b != 4'd0) begin
                state_nx = S_OUT;
                char_nx  = 8'h3D;
                stb_nx   = 1'b1;
            end
            else err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_A;
            acc_a      <= '0;
            acc_b      <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            o_op       <= '0;
            o_char     <= '0;
            o_char_stb <= 1'b0;
            o_err      <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            state      <= state_nx;
            acc_a      <= acc_a_nx;
            acc_b      <= acc_b_nx;
            cnt_a      <= cnt_a_nx;
            cnt_b      <= cnt_b_nx;
            o_op       <= op_nx;
            o_char     <= char_nx;
            o_char_stb <= stb_nx;
            o_err      <= err_nx;
            o_valid    <= state_nx == S_OUT;
        end
    end

    assign o_opa   = acc_a;
    assign o_opb   = acc_b;
    assign o_state = state;
endmodule

// File: tb/tb_calc_key_entry.sv
// tb_calc_key_entry: table vectors, corner sequences and a randomized run against a key-level calculator model
module tb_calc_key_entry;
    localparam int DT = 4;

    logic        clk = 1'b0, rst = 1'b0, i_tick = 1'b0, i_ready = 1'b0;
    logic [11:0] i_sw_push = '0;
    logic [2:0]  i_op_sel = '0;
    logic [7:0]  o_opa, o_opb, o_char;
    logic [2:0]  o_op;
    logic        o_valid, o_char_stb, o_err;
    logic [1:0]  o_state;

    calc_key_entry #(.DEBOUNCE_TICKS(DT), .MAX_DIGITS(3)) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_sw_push(i_sw_push), .i_op_sel(i_op_sel),
        .i_ready(i_ready), .o_opa(o_opa), .o_opb(o_opb), .o_op(o_op), .o_valid(o_valid),
        .o_char(o_char), .o_char_stb(o_char_stb), .o_err(o_err), .o_state(o_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int got_chars[$];
    int exp_chars[$];
    int got_err = 0, exp_err = 0;
    int op_tbl[7] = '{43, 45, 215, 47, 247, 94, 33};
    int m_lvl[12], m_cnt[12];
    int m_a, m_b, m_na, m_nb, m_op, m_st;
    logic [11:0] one = 12'd1;

    always @(negedge clk)
        if (rst) begin
            if (o_char_stb) got_chars.push_back(int'(o_char));
            if (o_err) got_err++;
        end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic m_clear();
        for (int i = 0; i < 12; i++) begin
            m_lvl[i] = 0;
            m_cnt[i] = 0;
        end
        m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_st = 0;
    endtask

    task automatic m_accept();
        m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_st = 0;
    endtask

    task automatic m_key(input int k);
        int acc, n, v;
        if (m_st == 2) return;
        if (k < 10) begin
            acc = m_st == 1 ? m_b : m_a;
            n   = m_st == 1 ? m_nb : m_na;
            v   = acc * 10 + k;
            if (n < 3 && v <= 255) begin
                if (m_st == 1) begin m_b = v; m_nb++; end
                else begin m_a = v; m_na++; end
                exp_chars.push_back(48 + k);
            end else exp_err++;
        end else if (k == 10) begin
            if (m_st == 0 && m_na > 0 && int'(i_op_sel) != 7) begin
                m_op = int'(i_op_sel);
                exp_chars.push_back(op_tbl[m_op]);
                m_st = m_op == 6 ? 2 : 1;
            end else exp_err++;
        end else begin
            if (m_st == 1 && m_nb > 0) begin
                m_st = 2;
                exp_chars.push_back(61);
            end else exp_err++;
        end
    endtask

    task automatic m_tick(input logic [11:0] sw);
        int first = -1;
        for (int i = 0; i < 12; i++) begin
            if (int'(sw[i]) != m_lvl[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == DT) begin
                    m_lvl[i] = 1 - m_lvl[i];
                    m_cnt[i] = 0;
                    if (m_lvl[i] == 1 && first < 0) first = i;
                end
            end else m_cnt[i] = 0;
        end
        if (first >= 0) m_key(first);
    endtask

    task automatic tick(input logic [11:0] sw);
        i_sw_push = sw;
        i_tick = 1'b1;
        @(posedge clk);
        #1 i_tick = 1'b0;
        m_tick(sw);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        repeat (6) tick(one << k);
        repeat (6) tick('0);
    endtask

    task automatic clear_obs();
        got_chars.delete();
        exp_chars.delete();
        got_err = 0;
        exp_err = 0;
    endtask

    task automatic accept();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_valid_drop", int'(o_valid), 0);
        chk("accept_state", int'(o_state), 0);
        i_ready = 1'b0;
        m_accept();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_valid_async", int'(o_valid), 0);
        chk("rst_state_async", int'(o_state), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_clear();
        clear_obs();
    endtask

    task automatic rand_seg();
        int k    = $urandom_range(0, 15);
        int k2   = $urandom_range(0, 11);
        int two  = $urandom_range(0, 7) == 0 ? 1 : 0;
        int hold = $urandom_range(1, 7);
        int rel  = $urandom_range(0, 6);
        logic [11:0] sw;
        if (k >= 12) k = 10 + (k & 1);
        i_op_sel = 3'($urandom_range(0, 7));
        for (int h = 0; h < hold; h++) begin
            sw = one << k;
            if (two != 0) sw = sw | (one << k2);
            if ($urandom_range(0, 5) == 0) sw = '0;
            tick(sw);
        end
        repeat (rel) tick('0);
        if (m_st == 2 && $urandom_range(0, 1) == 1) accept();
        chk("rnd_opa", int'(o_opa), m_a);
        chk("rnd_opb", int'(o_opb), m_b);
        chk("rnd_op", int'(o_op), m_op);
        chk("rnd_state", int'(o_state), m_st);
        chk("rnd_valid", int'(o_valid), m_st == 2 ? 1 : 0);
        chk("rnd_err", got_err, exp_err);
        chk("rnd_nchar", got_chars.size(), exp_chars.size());
        for (int i = 0; i < exp_chars.size() && i < got_chars.size(); i++)
            chk("rnd_char", got_chars[i], exp_chars[i]);
        clear_obs();
        if ($urandom_range(0, 29) == 0) do_reset();
    endtask

    typedef struct {
        int act;
        int key;
        int sel;
        int opa;
        int opb;
        int op;
        int st;
        int err;
        int chr;
    } row_t;

    row_t rows[$];

    initial begin
        row_t v;
        int bnc[6] = '{1, 0, 1, 1, 1, 1};
        rows.push_back('{0, 1, 0, 1, 0, 0, 0, 0, 'h31});
        rows.push_back('{0, 2, 0, 12, 0, 0, 0, 0, 'h32});
        rows.push_back('{0, 10, 0, 12, 0, 0, 1, 0, 'h2B});
        rows.push_back('{0, 3, 0, 12, 3, 0, 1, 0, 'h33});
        rows.push_back('{0, 4, 0, 12, 34, 0, 1, 0, 'h34});
        rows.push_back('{0, 11, 0, 12, 34, 0, 2, 0, 'h3D});
        rows.push_back('{0, 7, 0, 12, 34, 0, 2, 0, -1});
        rows.push_back('{1, 0, 0, 0, 0, 0, 0, 0, -1});
        rows.push_back('{0, 2, 0, 2, 0, 0, 0, 0, 'h32});
        rows.push_back('{0, 5, 0, 25, 0, 0, 0, 0, 'h35});
        rows.push_back('{0, 6, 0, 25, 0, 0, 0, 1, -1});
        rows.push_back('{2, 0, 0, 0, 0, 0, 0, 0, -1});
        rows.push_back('{0, 2, 0, 2, 0, 0, 0, 0, 'h32});
        rows.push_back('{0, 5, 0, 25, 0, 0, 0, 0, 'h35});
        rows.push_back('{0, 5, 0, 255, 0, 0, 0, 0, 'h35});
        rows.push_back('{0, 9, 0, 255, 0, 0, 0, 1, -1});
        rows.push_back('{0, 10, 6, 255, 0, 6, 2, 0, 'h21});
        rows.push_back('{0, 3, 0, 255, 0, 6, 2, 0, -1});
        rows.push_back('{2, 0, 0, 0, 0, 0, 0, 0, -1});
        rows.push_back('{0, 11, 0, 0, 0, 0, 0, 1, -1});
        rows.push_back('{0, 1, 0, 1, 0, 0, 0, 0, 'h31});
        rows.push_back('{0, 10, 7, 1, 0, 0, 0, 1, -1});
        rows.push_back('{0, 10, 3, 1, 0, 3, 1, 0, 'h2F});
        rows.push_back('{0, 11, 0, 1, 0, 3, 1, 1, -1});
        rows.push_back('{0, 10, 0, 1, 0, 3, 1, 1, -1});
        rows.push_back('{0, 9, 0, 1, 9, 3, 1, 0, 'h39});
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_opa", int'(o_opa), 0);
        chk("reset_opb", int'(o_opb), 0);
        chk("reset_op", int'(o_op), 0);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_char", int'(o_char), 0);
        chk("reset_stb", int'(o_char_stb), 0);
        chk("reset_err", int'(o_err), 0);
        chk("reset_state", int'(o_state), 0);
        rst = 1'b1;

        for (int r = 0; r < rows.size(); r++) begin
            v = rows[r];
            clear_obs();
            i_op_sel = 3'(v.sel);
            if (v.act == 0) press(v.key);
            else if (v.act == 1) accept();
            else do_reset();
            chk($sformatf("row%0d_opa", r), int'(o_opa), v.opa);
            chk($sformatf("row%0d_opb", r), int'(o_opb), v.opb);
            chk($sformatf("row%0d_op", r), int'(o_op), v.op);
            chk($sformatf("row%0d_state", r), int'(o_state), v.st);
            chk($sformatf("row%0d_valid", r), int'(o_valid), v.st == 2 ? 1 : 0);
            chk($sformatf("row%0d_err", r), got_err, v.err);
            chk($sformatf("row%0d_nchar", r), got_chars.size(), v.chr < 0 ? 0 : 1);
            if (v.chr >= 0 && got_chars.size() > 0)
                chk($sformatf("row%0d_char", r), got_chars[0], v.chr);
        end

        clear_obs();
        i_op_sel = 3'd0;
        repeat (6) tick(12'h088);
        repeat (6) tick('0);
        chk("simul_nchar", got_chars.size(), 1);
        if (got_chars.size() > 0) chk("simul_char", got_chars[0], 'h33);
        chk("simul_opb", int'(o_opb), 93);
        chk("simul_err", got_err, 0);

        rst = 1'b0;
        #2;
        chk("midb_rst_opa", int'(o_opa), 0);
        chk("midb_rst_opb", int'(o_opb), 0);
        chk("midb_rst_op", int'(o_op), 0);
        chk("midb_rst_char", int'(o_char), 0);
        chk("midb_rst_state", int'(o_state), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_clear();
        clear_obs();

        for (int i = 0; i < 6; i++) tick(bnc[i] != 0 ? 12'h020 : 12'h000);
        repeat (6) tick('0);
        chk("bounce_nchar", got_chars.size(), 1);
        if (got_chars.size() > 0) chk("bounce_char", got_chars[0], 'h35);
        chk("bounce_opa", int'(o_opa), 5);
        chk("bounce_err", got_err, 0);

        do_reset();
        for (int s = 0; s < 150; s++) rand_seg();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
Front-end input stage of the push-button calculator, sitting directly upstream of the LCD/calculator top. Debounces the 12 push switches on the 100 Hz sample strobe and turns accepted key presses into two 8-bit operands and an operator code. Presents the completed expression to the downstream arithmetic/LCD stage over a valid/ready handshake. Emits a per-key ASCII character strobe for the LCD echo.

Parameters:
DEBOUNCE_TICKS, 4, consecutive identical i_tick samples required to change a debounced key level (range 2..15)
MAX_DIGITS, 3, maximum decimal digits per operand

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
i_tick  input  1  sample strobe, one clk wide, nominally 100 Hz
i_sw_push  input  12  raw push switches; [9:0] digits 0-9, [10] OP, [11] EQ
i_op_sel  input  3  operator from DIP switches: 0 +, 1 -, 2 mul, 3 div, 4 rem, 5 pow, 6 factorial, 7 reserved
i_ready  input  1  downstream accepts expression
o_opa  output  8  operand A
o_opb  output  8  operand B (0 for factorial)
o_op  output  3  latched operator code
o_valid  output  1  expression complete; held until accepted
o_char  output  8  ASCII of last accepted key
o_char_stb  output  1  one-clk pulse when o_char updates
o_err  output  1  one-clk pulse on a rejected key
o_state  output  2  FSM state, for LED debug

Behaviour:
- Reset (rst low, async): all outputs 0; FSM in S_A; accumulators, digit counters, debounce counters and levels cleared. Applies mid-entry and while o_valid is high; o_valid drops immediately.
- Debounce, per bit, evaluated only on i_tick: a raw sample differing from the debounced level increments that bit's counter; a sample equal to the level clears the counter. When the counter reaches DEBOUNCE_TICKS, the level flips and the counter clears.
- A press event is a 0->1 transition of the debounced level. Events are registered one clk after the deciding tick.
- Simultaneous press events in one tick: the lowest index wins; the others are discarded and do not fire later while held.
- FSM encoding: S_A=0, S_B=1, S_OUT=2.
- S_A:
  - Digit d: acc_a := acc_a*10 + d, if cnt_a < MAX_DIGITS and the result <= 255. Otherwise o_err pulses and acc_a is unchanged.
  - OP with cnt_a = 0, or OP with i_op_sel = 7: o_err pulses.
  - OP with op 0..5: latch op, go to S_B.
  - OP with op 6: latch op, opb := 0, go to S_OUT.
  - EQ: o_err pulses.
- S_B:
  - Digits: same rule as S_A, applied to acc_b/cnt_b.
  - OP: o_err pulses; operator is unchanged.
  - EQ with cnt_b >= 1: go to S_OUT. With cnt_b = 0: o_err pulses.
- S_OUT:
  - o_valid = 1; o_opa, o_opb and o_op stay stable.
  - All key events are dropped, with no err and no char strobe.
  - When o_valid & i_ready in a cycle: at the next edge clear accumulators and counters, o_valid := 0, go to S_A.
  - i_ready outside S_OUT is ignored.
- o_valid latency: rises the clk after the EQ event is registered (or after OP for factorial).
- o_opa and o_opb track acc_a and acc_b live during entry.
- Char echo: each accepted key sets o_char and pulses o_char_stb in the same cycle the state update takes effect.
  - Digit: 0x30+d.
  - OP: + 0x2B, - 0x2D, mul 0xD7, div 0x2F, rem 0xF7, pow 0x5E, factorial 0x21.
  - EQ: 0x3D.
  - Rejected keys produce no char strobe.
- Arithmetic: the multiply-by-10 is computed at 12 bits; the overflow check is against 255.
- i_tick held high continuously is legal; it samples every clk.

Test Plan:
- Keys 1,2 / OP(op=0) / 3,4 / EQ, each held 6 ticks, i_ready=0: o_opa=12, o_opb=34, o_op=0, o_valid stays 1; chars 0x31,0x32,0x2B,0x33,0x34,0x3D. Then i_ready=1 for one cycle: o_valid=0 next cycle, o_state=0.
- Key 5 bouncing 1,0,1,1,1,1 ticks with DEBOUNCE_TICKS=4: exactly one event; acc_a=5.
- Keys 2,5,6: o_err pulses on 6, o_opa=25. Then keys 2,5,5,9: o_opa=255, o_err pulses on the fourth digit.
- Key 5, OP with op=6: o_valid=1, o_opb=0, o_op=6, char 0x21. Keys pressed while valid: no strobe, no change.
- EQ in S_A, OP with op=7, EQ in S_B with no digits: three o_err pulses, no state change.
- Keys 3 and 7 debounced in the same tick: only 3 accepted. Then rst low mid-S_B: all outputs 0, state S_A.
